// File: rtl/compute_clock_scheduler.sv
// rtl/compute_clock_scheduler.sv - compute clock enable sequencer with round-robin stall arbitration
//
// Runs the compute clock for an exact number of root-clock cycles. Any stall
// requester pauses the run, and it is granted only once the enable has been
// low long enough for the clock buffer to be gated.
//
// Ports:
//   root_clock        control-domain clock, all flops on its rising edge
//   reset_n_trigger   asynchronous active-low reset
//   locked            clock-generator lock; low gates the enable
//   start             one-cycle pulse launching a run (ignored while busy)
//   start_cycles      number of enabled cycles in the run, sampled with start
//   abort             level; ends the current run early
//   stall_req         per-source stall request, held until the source is done
//   stall_gnt         one-hot or zero; a grant means the compute clock is gated
//   compute_clock_en  registered enable to the compute clock buffer
//   busy              high from accepted start until done
//   done              one-cycle pulse at the end of a run
//   aborted           valid with done; run ended by abort
//   cycles_run        enabled cycles in the current or last run
module compute_clock_scheduler #(
    parameter int NUM_STALL_SRC = 4,
    parameter int COUNT_WIDTH   = 32
) (
    input  logic                     root_clock,
    input  logic                     reset_n_trigger,
    input  logic                     locked,
    input  logic                     start,
    input  logic [COUNT_WIDTH-1:0]   start_cycles,
    input  logic                     abort,
    input  logic [NUM_STALL_SRC-1:0] stall_req,
    output logic [NUM_STALL_SRC-1:0] stall_gnt,
    output logic                     compute_clock_en,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [COUNT_WIDTH-1:0]   cycles_run
);

    localparam int PTR_WIDTH = (NUM_STALL_SRC > 1) ? $clog2(NUM_STALL_SRC) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_STALLED,
        ST_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [COUNT_WIDTH-1:0]   cycles_run_q, cycles_run_d;
    logic                     en_q, en_d;
    logic [NUM_STALL_SRC-1:0] gnt_q, gnt_d;
    logic [PTR_WIDTH-1:0]     ptr_q, ptr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     aborted_q, aborted_d;
    logic                     abort_hit_q, abort_hit_d;
    logic                     from_idle_q, from_idle_d;

    logic [COUNT_WIDTH-1:0]   remaining_next;
    logic                     any_req;
    logic                     abort_now;
    logic                     gnt_held;
    logic                     finish_by_abort;
    logic                     win_found;
    logic [PTR_WIDTH-1:0]     win_idx;
    logic [PTR_WIDTH-1:0]     cand;

    // en_q high means the compute clock really ticked this cycle, so the
    // budget is charged from the registered enable, never from the inputs.
    assign remaining_next = remaining_q - COUNT_WIDTH'(en_q);
    assign any_req        = |stall_req;
    assign gnt_held       = |(gnt_q & stall_req);
    // abort only means something inside a run; it is latched so a short
    // pulse still ends the run once the clock is gated.
    assign abort_now      = busy_q & (abort | abort_hit_q);

    // Round-robin winner: first requester after the last granted index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int i = 1; i <= NUM_STALL_SRC; i++) begin
            cand = PTR_WIDTH'((int'(ptr_q) + i) % NUM_STALL_SRC);
            if (!win_found && stall_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // State register (and all other flops)
    always_ff @(posedge root_clock or negedge reset_n_trigger) begin
        if (!reset_n_trigger) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            cycles_run_q <= '0;
            en_q         <= 1'b0;
            gnt_q        <= '0;
            ptr_q        <= PTR_WIDTH'(NUM_STALL_SRC - 1);
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_hit_q  <= 1'b0;
            from_idle_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            cycles_run_q <= cycles_run_d;
            en_q         <= en_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_hit_q  <= abort_hit_d;
            from_idle_q  <= from_idle_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d         = state_q;
        finish_by_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else if (any_req) begin
                    // Clock already gated in IDLE, so no drain cycle needed.
                    state_d = ST_STALLED;
                end
            end
            ST_RUN: begin
                if (remaining_next == '0) begin
                    state_d = ST_FINISH;
                end else if (abort_now) begin
                    // Finish only after one cycle with the enable low, so
                    // done never overlaps a live compute clock.
                    if (!en_q) begin
                        state_d         = ST_FINISH;
                        finish_by_abort = 1'b1;
                    end
                end else if (any_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort_now) begin
                    state_d         = ST_FINISH;
                    finish_by_abort = 1'b1;
                end else begin
                    state_d = ST_STALLED;
                end
            end
            ST_STALLED: begin
                // Leave only between grants: no grant, or the granted source
                // released at this edge.
                if (!gnt_held) begin
                    if (abort_now) begin
                        state_d         = ST_FINISH;
                        finish_by_abort = 1'b1;
                    end else if (!any_req) begin
                        state_d = from_idle_q ? ST_IDLE : ST_RUN;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        remaining_d  = remaining_q;
        cycles_run_d = cycles_run_q;
        gnt_d        = '0;
        ptr_d        = ptr_q;
        busy_d       = busy_q;
        from_idle_d  = from_idle_q;

        if (state_q == ST_IDLE && state_d == ST_RUN) begin
            remaining_d  = start_cycles;
            cycles_run_d = '0;
            busy_d       = 1'b1;
        end else if (state_q == ST_RUN) begin
            remaining_d  = remaining_next;
            cycles_run_d = cycles_run_q + COUNT_WIDTH'(en_q);
        end

        if (state_d == ST_FINISH) begin
            busy_d = 1'b0;
        end

        if (state_q == ST_IDLE && state_d == ST_STALLED) begin
            from_idle_d = 1'b1;
        end else if (state_q == ST_DRAIN) begin
            from_idle_d = 1'b0;
        end

        // A released grant always leaves one empty cycle before the next.
        if (state_q == ST_STALLED && state_d == ST_STALLED) begin
            if (gnt_held) begin
                gnt_d = gnt_q;
            end else if (gnt_q == '0 && win_found && !abort_now) begin
                gnt_d[win_idx] = 1'b1;
                ptr_d          = win_idx;
            end
        end

        // state_d == ST_RUN already implies remaining_next != 0.
        en_d = (state_q == ST_RUN) && (state_d == ST_RUN) && !any_req
               && !abort_now && locked;

        done_d      = (state_d == ST_FINISH);
        aborted_d   = (state_d == ST_FINISH) && finish_by_abort;
        abort_hit_d = (state_d == ST_FINISH || state_d == ST_IDLE) ? 1'b0
                      : (abort_hit_q | (busy_q & abort));
    end

    assign stall_gnt        = gnt_q;
    assign compute_clock_en = en_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign cycles_run       = cycles_run_q;

endmodule

// File: doc/compute_clock_scheduler.md
# compute_clock_scheduler

Sequences the compute clock enable that gates the compute-core clock buffer. It runs the compute domain for an exact, host-programmed number of root-clock cycles, and pauses it when any of several requesters (memory, cache, host debug) asks for a stall. Stalls are granted round-robin, only once the compute clock is provably gated. The block sits in the control domain between the controller and the clock-distribution block's `compute_clock_en` input.

## Interface
- NUM_STALL_SRC, 4, number of stall requesters (2..8)
- COUNT_WIDTH, 32, width of the cycle budget and counters
- root_clock  in  1  control-domain clock; every flop is on its rising edge
- reset_n_trigger  in  1  asynchronous, active-low reset
- locked  in  1  clock-generator lock; synchronous to root_clock
- start  in  1  one-cycle pulse that launches a run
- start_cycles  in  COUNT_WIDTH  number of enabled cycles in the run; sampled with start
- abort  in  1  level; ends the current run early
- stall_req  in  NUM_STALL_SRC  per-source stall request, held high until the source is done
- stall_gnt  out  NUM_STALL_SRC  one-hot or zero; a grant means the compute clock is gated
- compute_clock_en  out  1  registered enable to the compute clock buffer
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at the end of a run
- aborted  out  1  valid with done; high if the run ended by abort
- cycles_run  out  COUNT_WIDTH  number of enabled cycles in the current or last run

## Operation
- Reset values: all outputs 0, state IDLE, `remaining` = 0, round-robin pointer = NUM_STALL_SRC-1 (source 0 wins first).
- States:
  - IDLE → RUN on `start` when no grant is active. `remaining` loads `start_cycles`, `cycles_run` clears, `busy` rises.
  - With `start_cycles` = 0: RUN → FINISH with no enabled cycle.
  - `start` while busy or while a grant is active is ignored.
- RUN:
  - `remaining'` = `remaining` − `compute_clock_en`; `cycles_run` increments on every cycle where `compute_clock_en` = 1.
  - `en'` = (`remaining'` ≠ 0) & ~|`stall_req` & ~`abort` & `locked`.
  - Total enabled cycles per unaborted run = `start_cycles` exactly; counters never wrap.
- RUN → FINISH when `remaining'` = 0; this has priority over a simultaneous stall request.
- RUN → DRAIN when any `stall_req` is high.
- DRAIN: exactly one cycle with `en` = 0, which covers the SYNC clock-enable latency of the buffer. Then → STALLED.
- STALLED:
  - Grant the round-robin winner among `stall_req`. The grant is held while that request stays high and drops the cycle after the request falls.
  - One idle cycle between grants. The pointer updates to the last granted index.
  - When no requests remain: return to RUN, or to IDLE if the stall was entered from IDLE.
- Stalls in IDLE: a request goes IDLE → STALLED directly, with no DRAIN, because the clock is already gated.
- abort:
  - In RUN or DRAIN: `en` = 0 next edge, → FINISH.
  - In STALLED: the current grant runs to completion, then → FINISH. No new grant is issued.
- FINISH: one cycle. `done` = 1, `aborted` set per cause, `busy` falls on the same edge. → IDLE.
- `locked` low: `en` forced 0 next edge; the FSM and counters freeze (no decrement). The run resumes when `locked` returns, provided no stall or abort is pending.
- Asynchronous reset mid-run: outputs go to their reset values immediately, including `compute_clock_en` = 0 and grants dropped.

## Timing
- `start` sampled at edge k → `compute_clock_en` = 1 after edge k+1, then high for `start_cycles` consecutive cycles if undisturbed.
- `done` asserts the cycle after the last enabled cycle.
- Stall: `stall_req` first high at edge k → `en` low after k, DRAIN cycle k+1, grant high after edge k+2.
- Release at edge j → grant low after j. The RUN re-enable appears after edge j+1.
- `abort` at edge k → `en` low after k; `done` after k+1 (from RUN).
- No combinational path from any input to `compute_clock_en` or `stall_gnt`.

## Test plan
- Basic run: `start` with `start_cycles`=5 → exactly 5 cycles of `en`=1, `cycles_run`=5, one `done` pulse, `aborted`=0, `busy` low after `done`.
- Zero budget: `start_cycles`=0 → `done` 2 cycles after `start`, `en` never high, `cycles_run`=0.
- Stall arbitration: `start_cycles`=20, and after 3 enabled cycles raise `stall_req`=4'b0101.
  - `en` drops, then one DRAIN cycle, then the grant goes to source 0, and to source 2 after source 0 releases.
  - Run resumes and total enabled cycles = 20.
- Round-robin fairness: repeated simultaneous requests from sources 1 and 3 → grants alternate 1, 3, 1, 3; never two grants at once.
- Abort while stalled: abort during a grant to source 2 → the grant stays until `stall_req[2]` falls, then `done`=1 with `aborted`=1 and no further grants.
- Lock loss and reset: drop `locked` for 4 cycles mid-run with `start_cycles`=10 → `en` is low for those cycles and the total enabled count is still 10. Then assert `reset_n_trigger`=0 mid-run → `en`, `busy` and grants go to 0 immediately.
